program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot/run sequencer upstream of the cpu top.
- Accepts a 32-bit word stream through a valid/ready handshake and writes it into instruction memory via the cpu external port 1, then into data memory via external port 2.
- Then raises the cpu `enable` for a programmed number of cycles and reports done.
- Replaces testbench-driven memory preload with a synthesizable controller.

Parameters:
- IMEM_DEPTH, 512, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 1024, data memory depth in 64-bit words.
- CNT_W, 32, width of word counters and run-cycle counter.

Ports:
- clk  in  1  main clock.
- arst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- start  in  1  single-cycle request to begin a load/run session; sampled in IDLE and DONE only.
- imem_words  in  CNT_W  number of instruction words to load; sampled on accepted start.
- dmem_words  in  CNT_W  number of 64-bit data words to load; sampled on accepted start.
- run_cycles  in  CNT_W  number of cycles cpu_enable stays high; sampled on accepted start.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  loader accepts a stream word.
- addr_ext  out  64  instruction memory byte address.
- wen_ext  out  1  instruction memory write enable.
- ren_ext  out  1  instruction memory read enable; constant 0.
- wdata_ext  out  32  instruction memory write word.
- addr_ext_2  out  64  data memory byte address.
- wen_ext_2  out  1  data memory write enable.
- ren_ext_2  out  1  data memory read enable; constant 0.
- wdata_ext_2  out  64  data memory write word.
- cpu_enable  out  1  drives cpu `enable`.
- busy  out  1  high in LOAD_I, LOAD_D and RUN.
- done  out  1  high in DONE.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; dmem half-word flag clear.
- States: IDLE, LOAD_I, LOAD_D, RUN, DONE.
- Start acceptance (IDLE or DONE only):
  - Start is accepted when imem_words <= IMEM_DEPTH and dmem_words <= DMEM_DEPTH. Latch all three counts, clear address counters, go to LOAD_I.
  - Zero counts skip their stage in the same transition order: LOAD_I -> LOAD_D -> RUN -> DONE.
  - Out-of-range counts raise cfg_err for 1 cycle; the state is unchanged.
  - start while busy is ignored.
- s_ready is 1 in LOAD_I and LOAD_D, else 0. A beat transfers on s_valid & s_ready. Gaps in s_valid are legal.
- LOAD_I:
  - Each beat k (k = 0..imem_words-1) produces, on the next cycle, wen_ext=1, addr_ext=4*k, wdata_ext=s_data, each for exactly 1 cycle. Fixed latency of 1 cycle, registered outputs.
  - After the beat that completes imem_words, go to LOAD_D.
  - wen_ext for the final write is still emitted on the cycle after that beat.
- LOAD_D:
  - Beats pair up: the first beat is the low half [31:0], the second is the high half [63:32].
  - On the high-half beat of pair j, the next cycle shows wen_ext_2=1, addr_ext_2=8*j, wdata_ext_2={high,low} for 1 cycle.
  - The low-half beat produces no write.
  - After pair dmem_words-1 is written, go to RUN.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, starting the cycle after entry, using a down-counter.
  - Memory write enables are 0 throughout.
  - When the counter expires, cpu_enable drops to 0 and the state becomes DONE.
- DONE: done=1, cpu_enable=0. Hold until a new start is accepted, which clears done the next cycle.
- Address arithmetic: unsigned; upper address bits are zero-extended to 64. Counters never exceed their depth because of the start check, so there is no wrap-around.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partially assembled data word is discarded. Memory contents are untouched.
- Simultaneous events: the last LOAD_I beat and the first LOAD_D beat cannot occur in the same cycle (one beat per cycle). s_valid outside the load states is ignored.

Decomposition:
- Shared package:
  - State encoding enum: IDLE=0, LOAD_I=1, LOAD_D=2, RUN=3, DONE=4, width 3.
  - Byte strides IMEM_STRIDE=4, DMEM_STRIDE=8.
  - Default depths.
- Sub-module: run_timer, a loadable down-counter with load, en and expired outputs. It is used for the RUN stage and is reusable for the later cycle-budget watchdog.

Test Plan:
- Reset, then start with imem_words=3, dmem_words=0, run_cycles=0, and stream 0x00000013, 0x00100093, 0x00208113 -> wen_ext pulses at addr 0, 4, 8 with those words, one cycle after each beat; done=1 with no cpu_enable.
- dmem_words=2, imem_words=0; stream 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> wen_ext_2 twice only: addr 0 with 0x2222222211111111, addr 8 with 0x4444444433333333.
- run_cycles=5 with counts 0 -> cpu_enable high exactly 5 cycles; busy high throughout; done on the following cycle; wen signals stay 0.
- imem_words=513 -> cfg_err 1-cycle pulse, state stays IDLE, s_ready=0; then a legal start proceeds normally.
- Stream with s_valid toggling 1,0,0,1 during LOAD_I -> exactly 2 writes at addr 0 and 4; no write on idle cycles.
- Assert arst_n low after the low-half beat in LOAD_D -> all outputs 0 immediately; after release, a fresh session writes addr_ext_2=0 with newly streamed halves, not the stale low half.

Source files
------------

// File: rtl/program_loader_pkg.sv
// ----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the boot/run sequencer:
//   - state_e      : sequencer state encoding
//   - *_STRIDE     : byte strides of instruction (32-bit) and data (64-bit) words
//   - *_DEF        : default memory depths and counter width
//   - byte_addr    : word index -> zero-extended 64-bit byte address
//   - next_stage   : first non-empty stage in the order LOAD_I, LOAD_D, RUN, DONE
// ----------------------------------------------------------------------------
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_I = 3'd1,
        ST_LOAD_D = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned IMEM_STRIDE    = 32'd4;
    localparam int unsigned DMEM_STRIDE    = 32'd8;
    localparam int unsigned IMEM_DEPTH_DEF = 32'd512;
    localparam int unsigned DMEM_DEPTH_DEF = 32'd1024;
    localparam int unsigned CNT_W_DEF      = 32'd32;

    // Word index to byte address; indices are bounded by the memory depth so
    // the product never wraps.
    function automatic logic [63:0] byte_addr(input logic [63:0] idx,
                                              input int unsigned stride);
        return idx * 64'(stride);
    endfunction

    // Stages with a zero count are skipped; callers pass 1'b0 for stages that
    // already lie behind them.
    function automatic state_e next_stage(input logic has_i,
                                          input logic has_d,
                                          input logic has_r);
        state_e st;
        if (has_i) begin
            st = ST_LOAD_I;
        end else if (has_d) begin
            st = ST_LOAD_D;
        end else if (has_r) begin
            st = ST_RUN;
        end else begin
            st = ST_DONE;
        end
        return st;
    endfunction

endpackage

// File: rtl/program_loader_run_timer.sv
// ----------------------------------------------------------------------------
// run_timer
// Loadable down-counter. Used to time the cpu run window; also intended for
// the cycle-budget watchdog.
// Ports:
//   clk, arst_n   : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over en_i)
//   load_val_i    : value to load
//   en_i          : decrement by one while non-zero
//   last_o        : count is 1, i.e. the current enabled cycle is the final one
//   expired_o     : count is 0
// ----------------------------------------------------------------------------
module run_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             last_o,
    output logic             expired_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(32'd1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise saturating decrement at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o    = (count_q == ONE);
    assign expired_o = (count_q == '0);

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Boot/run sequencer in front of the cpu. Streams 32-bit words into
// instruction memory (external port 1), then pairs of words into 64-bit data
// memory (external port 2), then enables the cpu for a programmed number of
// cycles and reports done.
// Ports:
//   clk, arst_n                 : clock, asynchronous active-low reset
//   start                       : session request (honoured in IDLE/DONE)
//   imem_words/dmem_words       : words to load per memory, checked on start
//   run_cycles                  : cycles of cpu_enable
//   s_valid/s_data/s_ready      : input word stream
//   addr_ext/wen_ext/ren_ext/wdata_ext         : instruction memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 : data memory port
//   cpu_enable, busy, done      : status; cfg_err pulses on a rejected start
// All outputs are registered.
// ----------------------------------------------------------------------------
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(32'd1);

    // Sequencer state and counters
    state_e           state_q,  state_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] imem_n_q, imem_n_d;
    logic [CNT_W-1:0] dmem_n_q, dmem_n_d;
    logic [CNT_W-1:0] run_n_q,  run_n_d;
    logic             half_q,   half_d;
    logic [31:0]      low_q,    low_d;

    // Registered outputs
    logic             s_ready_q, s_ready_d;
    logic             wen_q,     wen_d;
    logic [63:0]      addr_q,    addr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic             wen2_q,    wen2_d;
    logic [63:0]      addr2_q,   addr2_d;
    logic [63:0]      wdata2_q,  wdata2_d;
    logic             cpu_en_q,  cpu_en_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             beat_s;
    logic             start_ok_s;
    logic             timer_load_s;
    logic             timer_en_s;
    logic             timer_last_s;
    logic             timer_expired_s;

    // s_ready is registered, so it already reflects the current load state.
    assign beat_s     = s_valid && s_ready_q;
    assign start_ok_s = (imem_words <= CNT_W'(IMEM_DEPTH)) &&
                        (dmem_words <= CNT_W'(DMEM_DEPTH));

    // Timer is loaded on the transition into RUN, from whichever count is
    // being latched or held this cycle.
    assign timer_load_s = (state_d == ST_RUN) && (state_q != ST_RUN);

    run_timer #(
        .CNT_W (CNT_W)
    ) u_run_timer (
        .clk        (clk),
        .arst_n     (arst_n),
        .load_i     (timer_load_s),
        .load_val_i (run_n_d),
        .en_i       (timer_en_s),
        .last_o     (timer_last_s),
        .expired_o  (timer_expired_s)
    );

    // Next-state, counter and output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        imem_n_d   = imem_n_q;
        dmem_n_d   = dmem_n_q;
        run_n_d    = run_n_q;
        half_d     = half_q;
        low_d      = low_q;
        wen_d      = 1'b0;
        addr_d     = 64'd0;
        wdata_d    = 32'd0;
        wen2_d     = 1'b0;
        addr2_d    = 64'd0;
        wdata2_d   = 64'd0;
        cfg_err_d  = 1'b0;
        timer_en_s = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (start_ok_s) begin
                        imem_n_d = imem_words;
                        dmem_n_d = dmem_words;
                        run_n_d  = run_cycles;
                        idx_d    = '0;
                        half_d   = 1'b0;
                        low_d    = 32'd0;
                        state_d  = next_stage(imem_words != '0,
                                              dmem_words != '0,
                                              run_cycles != '0);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_LOAD_I: begin
                if (beat_s) begin
                    wen_d   = 1'b1;
                    addr_d  = byte_addr(64'(idx_q), IMEM_STRIDE);
                    wdata_d = s_data;
                    if ((idx_q + ONE) == imem_n_q) begin
                        idx_d   = '0;
                        state_d = next_stage(1'b0, dmem_n_q != '0, run_n_q != '0);
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end else begin
                    state_d = ST_LOAD_I;
                end
            end

            ST_LOAD_D: begin
                if (beat_s) begin
                    if (!half_q) begin
                        // Low half: hold it until its partner arrives.
                        low_d  = s_data;
                        half_d = 1'b1;
                    end else begin
                        wen2_d   = 1'b1;
                        addr2_d  = byte_addr(64'(idx_q), DMEM_STRIDE);
                        wdata2_d = {s_data, low_q};
                        half_d   = 1'b0;
                        if ((idx_q + ONE) == dmem_n_q) begin
                            idx_d   = '0;
                            state_d = next_stage(1'b0, 1'b0, run_n_q != '0);
                        end else begin
                            idx_d = idx_q + ONE;
                        end
                    end
                end else begin
                    state_d = ST_LOAD_D;
                end
            end

            ST_RUN: begin
                timer_en_s = 1'b1;
                // Expired is a guard only; RUN is never entered with a zero count.
                if (timer_last_s || timer_expired_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs follow the next state so that they line up with it.
        s_ready_d = (state_d == ST_LOAD_I) || (state_d == ST_LOAD_D);
        busy_d    = (state_d == ST_LOAD_I) || (state_d == ST_LOAD_D) ||
                    (state_d == ST_RUN);
        cpu_en_d  = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            imem_n_q  <= '0;
            dmem_n_q  <= '0;
            run_n_q   <= '0;
            half_q    <= 1'b0;
            low_q     <= 32'd0;
            s_ready_q <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 32'd0;
            wen2_q    <= 1'b0;
            addr2_q   <= 64'd0;
            wdata2_q  <= 64'd0;
            cpu_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            imem_n_q  <= imem_n_d;
            dmem_n_q  <= dmem_n_d;
            run_n_q   <= run_n_d;
            half_q    <= half_d;
            low_q     <= low_d;
            s_ready_q <= s_ready_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen2_q    <= wen2_d;
            addr2_q   <= addr2_d;
            wdata2_q  <= wdata2_d;
            cpu_en_q  <= cpu_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign addr_ext    = addr_q;
    assign wen_ext     = wen_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wdata_q;
    assign addr_ext_2  = addr2_q;
    assign wen_ext_2   = wen2_q;
    assign ren_ext_2   = 1'b0;
    assign wdata_ext_2 = wdata2_q;
    assign cpu_enable  = cpu_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_program_loader.sv
// ----------------------------------------------------------------------------
// tb_program_loader
// Directed self-checking bench for program_loader. Inputs change 1 ns after
// each rising edge; registered outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_program_loader;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [31:0] imem_words;
    logic [31:0] dmem_words;
    logic [31:0] run_cycles;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks;
    int errors;

    program_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .imem_words  (imem_words),
        .dmem_words  (dmem_words),
        .run_cycles  (run_cycles),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] ni, input logic [31:0] nd, input logic [31:0] nr);
        imem_words = ni;
        dmem_words = nd;
        run_cycles = nr;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        logic [255:0] all_out;
        arst_n = 1'b0;
        tick();
        all_out = {s_ready, addr_ext, wen_ext, ren_ext, wdata_ext, addr_ext_2,
                   wen_ext_2, ren_ext_2, wdata_ext_2, cpu_enable, busy, done, cfg_err};
        checks++;
        if (all_out !== 256'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", all_out);
        end
        arst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, s_ready, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got %b expected 0000", {busy, done, s_ready, cfg_err});
        end
    endtask

    task automatic test_imem_load();
        logic [31:0] words [3];
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        words[2] = 32'h00208113;
        do_start(32'd3, 32'd0, 32'd0);
        checks++;
        if ({busy, s_ready, wen_ext} !== 3'b110) begin
            errors++;
            $display("FAIL imem_enter got busy/ready/wen %b expected 110", {busy, s_ready, wen_ext});
        end
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data  = words[k];
            tick();
            checks++;
            if ({wen_ext, addr_ext, wdata_ext, wen_ext_2, cpu_enable} !==
                {1'b1, 64'(4 * k), words[k], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL imem_write k=%0d got wen=%b addr=%h data=%h expected wen=1 addr=%h data=%h",
                         k, wen_ext, addr_ext, wdata_ext, 64'(4 * k), words[k]);
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if ({wen_ext, done, cpu_enable, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL imem_done got wen/done/cpu_en/busy %b expected 0100",
                     {wen_ext, done, cpu_enable, busy});
        end
    endtask

    task automatic test_dmem_load();
        logic [31:0] halves [4];
        logic [63:0] exp_data;
        int          n_writes;
        halves[0] = 32'h11111111;
        halves[1] = 32'h22222222;
        halves[2] = 32'h33333333;
        halves[3] = 32'h44444444;
        n_writes  = 0;
        do_start(32'd0, 32'd2, 32'd0);
        checks++;
        if ({done, busy, s_ready} !== 3'b011) begin
            errors++;
            $display("FAIL dmem_enter got done/busy/ready %b expected 011", {done, busy, s_ready});
        end
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = halves[k];
            tick();
            if (wen_ext_2) n_writes++;
            if (k % 2 == 1) begin
                exp_data = {halves[k], halves[k-1]};
                checks++;
                if ({wen_ext_2, addr_ext_2, wdata_ext_2} !== {1'b1, 64'(8 * (k / 2)), exp_data}) begin
                    errors++;
                    $display("FAIL dmem_write pair=%0d got wen=%b addr=%h data=%h expected wen=1 addr=%h data=%h",
                             k / 2, wen_ext_2, addr_ext_2, wdata_ext_2, 64'(8 * (k / 2)), exp_data);
                end
            end else begin
                checks++;
                if ({wen_ext_2, wen_ext} !== 2'b00) begin
                    errors++;
                    $display("FAIL dmem_low_no_write k=%0d got wen2/wen %b expected 00", k, {wen_ext_2, wen_ext});
                end
            end
        end
        s_valid = 1'b0;
        tick();
        if (wen_ext_2) n_writes++;
        checks++;
        if (n_writes != 2 || done !== 1'b1) begin
            errors++;
            $display("FAIL dmem_total got writes=%0d done=%b expected writes=2 done=1", n_writes, done);
        end
    endtask

    task automatic test_run();
        do_start(32'd0, 32'd0, 32'd5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({cpu_enable, busy, done, wen_ext, wen_ext_2} !== 5'b11000) begin
                errors++;
                $display("FAIL run_cycle i=%0d got en/busy/done/wen/wen2 %b expected 11000",
                         i, {cpu_enable, busy, done, wen_ext, wen_ext_2});
            end
            tick();
        end
        checks++;
        if ({cpu_enable, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL run_end got en/busy/done %b expected 001", {cpu_enable, busy, done});
        end
    endtask

    task automatic test_cfg_err();
        int n_err;
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 32'hCAFEF00D;
        do_start(32'd513, 32'd0, 32'd0);
        checks++;
        if ({cfg_err, busy, s_ready, done, wen_ext} !== 5'b10000) begin
            errors++;
            $display("FAIL cfg_err_imem got err/busy/ready/done/wen %b expected 10000",
                     {cfg_err, busy, s_ready, done, wen_ext});
        end
        tick();
        checks++;
        if ({cfg_err, busy, s_ready, wen_ext} !== 4'b0000) begin
            errors++;
            $display("FAIL cfg_err_pulse got err/busy/ready/wen %b expected 0000",
                     {cfg_err, busy, s_ready, wen_ext});
        end
        do_start(32'd0, 32'd1025, 32'd0);
        checks++;
        if ({cfg_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL cfg_err_dmem got err/busy %b expected 10", {cfg_err, busy});
        end
        // Largest legal instruction image
        do_start(32'd512, 32'd0, 32'd0);
        checks++;
        if ({cfg_err, busy, s_ready} !== 3'b011) begin
            errors++;
            $display("FAIL cfg_max_accept got err/busy/ready %b expected 011", {cfg_err, busy, s_ready});
        end
        n_err = 0;
        for (int k = 0; k < 512; k++) begin
            s_valid = 1'b1;
            s_data  = 32'h5A000000 + 32'(k);
            tick();
            if ({wen_ext, addr_ext, wdata_ext} !== {1'b1, 64'(4 * k), 32'h5A000000 + 32'(k)}) n_err++;
        end
        checks++;
        if (n_err != 0 || addr_ext !== 64'd2044 || done !== 1'b1) begin
            errors++;
            $display("FAIL imem_full got bad=%0d last_addr=%h done=%b expected bad=0 last_addr=7fc done=1",
                     n_err, addr_ext, done);
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_gaps();
        logic       v_pat [4];
        logic [3:0] exp_wen;
        logic [3:0] got_wen;
        v_pat[0] = 1'b1;
        v_pat[1] = 1'b0;
        v_pat[2] = 1'b0;
        v_pat[3] = 1'b1;
        exp_wen  = 4'b1001;
        do_start(32'd2, 32'd0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            s_valid = v_pat[k];
            s_data  = v_pat[k] ? (32'hA0000001 + 32'(k / 3)) : 32'hDEADBEEF;
            // A start while busy must not disturb the session.
            start      = (k == 1);
            imem_words = 32'd7;
            tick();
            start   = 1'b0;
            got_wen[k] = wen_ext;
            if (k == 3) begin
                checks++;
                if ({addr_ext, wdata_ext, done} !== {64'd4, 32'hA0000002, 1'b1}) begin
                    errors++;
                    $display("FAIL gap_second got addr=%h data=%h done=%b expected addr=4 data=a0000002 done=1",
                             addr_ext, wdata_ext, done);
                end
            end else if (k == 0) begin
                checks++;
                if ({addr_ext, wdata_ext} !== {64'd0, 32'hA0000001}) begin
                    errors++;
                    $display("FAIL gap_first got addr=%h data=%h expected addr=0 data=a0000001", addr_ext, wdata_ext);
                end
            end
        end
        checks++;
        if (got_wen !== exp_wen) begin
            errors++;
            $display("FAIL gap_wen_pattern got %b expected %b", got_wen, exp_wen);
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_start(32'd0, 32'd1, 32'd3);
        s_valid = 1'b1;
        s_data  = 32'h55555555;
        tick();
        s_valid = 1'b0;
        #1;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, busy, wen_ext_2, cpu_enable, done, addr_ext_2, wdata_ext_2} !== 133'd0) begin
            errors++;
            $display("FAIL reset_mid got ready=%b busy=%b wen2=%b en=%b done=%b expected all 0",
                     s_ready, busy, wen_ext_2, cpu_enable, done);
        end
        tick();
        arst_n = 1'b1;
        tick();
        do_start(32'd0, 32'd1, 32'd0);
        s_valid = 1'b1;
        s_data  = 32'h66666666;
        tick();
        s_data  = 32'h77777777;
        tick();
        s_valid = 1'b0;
        checks++;
        if ({wen_ext_2, addr_ext_2, wdata_ext_2} !== {1'b1, 64'd0, 64'h7777777766666666}) begin
            errors++;
            $display("FAIL reset_fresh_pair got wen=%b addr=%h data=%h expected wen=1 addr=0 data=7777777766666666",
                     wen_ext_2, addr_ext_2, wdata_ext_2);
        end
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        arst_n     = 1'b0;
        start      = 1'b0;
        imem_words = 32'd0;
        dmem_words = 32'd0;
        run_cycles = 32'd0;
        s_valid    = 1'b0;
        s_data     = 32'd0;
        test_reset();
        test_imem_load();
        test_dmem_load();
        test_run();
        test_cfg_err();
        test_gaps();
        test_reset_mid();
        checks++;
        if ({ren_ext, ren_ext_2} !== 2'b00) begin
            errors++;
            $display("FAIL ren_const got %b expected 00", {ren_ext, ren_ext_2});
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
